// File: rtl/i2s_dac_serializer.sv
// I2S DAC transmitter: buffers stereo sample pairs in a small FIFO and shifts them
// MSB-first onto AUD_DACDAT, timed by codec BCLK/LRCK sampled on CLOCK_50.
//
// state | meaning
// IDLE  | output 0, waiting for the first left-frame start
// DELAY | I2S one-bit delay slot after an LRCK edge, output 0
// SHIFT | driving word bits MSB-first, one per BCLK falling edge
// PAD   | word finished, output 0 until the next LRCK edge
module i2s_dac_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata_left,
  input  logic [DATA_WIDTH-1:0] writedata_right,
  output logic                  write_ready,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT,
  output logic                  underflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_t;

  logic bclk_s1, bclk_s2, bclk_prev;
  logic lrck_s1, lrck_s2, lrck_prev;
  logic bclk_fall, lr_edge, frame_start, left_start, right_start;

  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [2*DATA_WIDTH-1:0] head;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    fifo_empty, push, pop;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   shifter, right_hold;
  logic [IDX_W-1:0]        bit_idx;

  // Identical synchroniser depth on both codec clocks keeps LRCK edges aligned with bclk_fall.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bclk_s1   <= 1'b0;
      bclk_s2   <= 1'b0;
      bclk_prev <= 1'b0;
      lrck_s1   <= 1'b0;
      lrck_s2   <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_s1   <= AUD_BCLK;
      bclk_s2   <= bclk_s1;
      bclk_prev <= bclk_s2;
      lrck_s1   <= AUD_DACLRCK;
      lrck_s2   <= lrck_s1;
      lrck_prev <= lrck_s2;
    end
  end

  assign bclk_fall   = bclk_prev & ~bclk_s2;
  assign lr_edge     = lrck_s2 ^ lrck_prev;
  assign frame_start = bclk_fall & lr_edge;
  assign left_start  = frame_start & ~lrck_s2;
  assign right_start = frame_start & lrck_s2;

  assign write_ready = (count < DEPTH_C);
  assign fifo_empty  = (count == '0);
  assign push        = write & write_ready;
  assign pop         = left_start & ~fifo_empty;
  assign head        = mem[rd_ptr];

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= {writedata_left, writedata_right};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      AUD_DACDAT <= 1'b0;
      underflow  <= 1'b0;
      shifter    <= '0;
      right_hold <= '0;
      bit_idx    <= '0;
    end else begin
      underflow <= 1'b0;
      if (left_start) begin
        if (!fifo_empty) begin
          shifter    <= head[2*DATA_WIDTH-1:DATA_WIDTH];
          right_hold <= head[DATA_WIDTH-1:0];
        end else begin
          shifter    <= '0;
          right_hold <= '0;
          underflow  <= 1'b1;
        end
        AUD_DACDAT <= 1'b0;
        state      <= DELAY;
      end else if (right_start && state != IDLE) begin
        shifter    <= right_hold;
        AUD_DACDAT <= 1'b0;
        state      <= DELAY;
      end else if (bclk_fall) begin
        case (state)
          IDLE: AUD_DACDAT <= 1'b0;
          // The fall that ends the delay slot already carries the MSB.
          DELAY: begin
            AUD_DACDAT <= shifter[DATA_WIDTH-1];
            bit_idx    <= IDX_W'(DATA_WIDTH - 2);
            state      <= SHIFT;
          end
          SHIFT: begin
            AUD_DACDAT <= shifter[bit_idx];
            if (bit_idx == '0) state <= PAD;
            else               bit_idx <= bit_idx - IDX_W'(1);
          end
          PAD:     AUD_DACDAT <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Bench for i2s_dac_serializer: directed pushes and codec frames; expected half-frames
// are queued at frame start and a BCLK-rising monitor rebuilds and compares each one.
module tb_i2s_dac_serializer;
  localparam int DW    = 24;
  localparam int DEPTH = 4;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          write = 1'b0;
  logic [DW-1:0] wl = '0, wr = '0;
  logic          write_ready;
  logic          AUD_BCLK = 1'b1;
  logic          AUD_DACLRCK = 1'b1;
  logic          AUD_DACDAT, underflow;

  always #5 CLOCK_50 = ~CLOCK_50;

  i2s_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .write(write),
    .writedata_left(wl), .writedata_right(wr), .write_ready(write_ready),
    .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
    .AUD_DACDAT(AUD_DACDAT), .underflow(underflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          lr;
    int            nb;
    logic [DW-1:0] word;
    bit            chk;
  } frame_t;

  frame_t            sb_q[$];
  logic [2*DW-1:0]   model_q[$];
  logic [DW-1:0]     m_rhold = '0;
  bit                m_idle = 1'b1;
  int                exp_uf = 0;
  int                uf_cycles = 0;

  function automatic logic [63:0] exp_bits(input logic [DW-1:0] w, input int nb);
    logic [63:0] e;
    e = '0;
    for (int n = 1; n <= nb; n++) begin
      logic b;
      b = (n >= 2 && n <= DW + 1) ? w[DW + 1 - n] : 1'b0;
      e = {e[62:0], b};
    end
    return e;
  endfunction

  // Monitor: one half-frame closes at the first BCLK rise that sees LRCK changed.
  logic        mon_lr = 1'b1;
  logic [63:0] cap = '0;
  int          ncap = 0;

  always @(posedge AUD_BCLK) begin
    if (AUD_DACLRCK !== mon_lr) begin
      if (ncap > 0) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underrun: got frame %0h with no expectation", cap);
        end else begin
          frame_t f;
          f = sb_q.pop_front();
          if (f.chk) begin
            check("frame_len", 64'(ncap), 64'(f.nb));
            check(f.lr ? "right_frame" : "left_frame", cap, exp_bits(f.word, f.nb));
          end
        end
      end
      ncap   = 0;
      cap    = '0;
      mon_lr = AUD_DACLRCK;
    end
    cap = {cap[62:0], AUD_DACDAT};
    ncap++;
  end

  always @(negedge CLOCK_50) if (underflow === 1'b1) uf_cycles++;

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit exp_rdy;
    exp_rdy = (model_q.size() < DEPTH);
    check("write_ready", 64'(write_ready), 64'(exp_rdy));
    write = 1'b1;
    wl    = l;
    wr    = r;
    tick(1);
    write = 1'b0;
    if (exp_rdy) model_q.push_back({l, r});
  endtask

  // One half-frame of nb BCLKs; rst_at>0 pulses reset after that many BCLKs.
  task automatic half_frame(input logic lr, input int nb, input bit chk, input int rst_at);
    frame_t f;
    f.lr = lr; f.nb = nb; f.chk = chk;
    if (!lr) begin
      if (model_q.size() > 0) begin
        logic [2*DW-1:0] p;
        p = model_q.pop_front();
        f.word  = p[2*DW-1:DW];
        m_rhold = p[DW-1:0];
      end else begin
        f.word  = '0;
        m_rhold = '0;
        exp_uf++;
      end
      m_idle = 1'b0;
    end else begin
      f.word = m_idle ? '0 : m_rhold;
    end
    sb_q.push_back(f);
    tick(1);
    AUD_DACLRCK = lr;
    for (int k = 0; k < nb; k++) begin
      AUD_BCLK = 1'b0;
      tick(8);
      AUD_BCLK = 1'b1;
      tick(8);
      if (rst_at > 0 && k == rst_at - 1) begin
        check("pre_reset_bit", 64'(AUD_DACDAT), 64'(1));
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("reset_dacdat", 64'(AUD_DACDAT), 64'(0));
        check("reset_write_ready", 64'(write_ready), 64'(1));
        model_q.delete();
        m_idle  = 1'b1;
        m_rhold = '0;
      end
    end
  endtask

  task automatic frame_pair(input int nb);
    half_frame(1'b0, nb, 1'b1, 0);
    half_frame(1'b1, nb, 1'b1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    tick(4);
    check("rst_dacdat", 64'(AUD_DACDAT), 64'(0));
    check("rst_underflow", 64'(underflow), 64'(0));
    check("rst_write_ready", 64'(write_ready), 64'(1));
    reset = 1'b0;
    tick(2);

    // Basic left/right word, then an empty left frame
    push_pair(24'hA5F00F, 24'h123456);
    frame_pair(32);
    frame_pair(32);
    check("uf_basic", 64'(uf_cycles), 64'(exp_uf));

    // Fill with BCLK stopped; fifth write must be dropped
    push_pair(24'h111111, 24'h222222);
    push_pair(24'h333333, 24'h444444);
    push_pair(24'h555555, 24'h666666);
    push_pair(24'h777777, 24'h888888);
    push_pair(24'h999999, 24'hAAAAAA);
    half_frame(1'b0, 32, 1'b1, 0);
    check("ready_after_pop", 64'(write_ready), 64'(1));
    half_frame(1'b1, 32, 1'b1, 0);
    frame_pair(32);
    frame_pair(32);
    frame_pair(32);
    frame_pair(32);
    check("uf_full", 64'(uf_cycles), 64'(exp_uf));

    // Empty FIFO: one underflow per left frame, zero output
    frame_pair(32);
    frame_pair(32);
    frame_pair(32);
    check("uf_empty", 64'(uf_cycles), 64'(exp_uf));

    // Ordering, then streaming through pointer wrap
    push_pair(24'hABCDEF, 24'hFEDCBA);
    push_pair(24'h800000, 24'h7FFFFF);
    push_pair(24'h000001, 24'hC3C3C3);
    frame_pair(32);
    frame_pair(32);
    frame_pair(32);
    for (int i = 0; i < 10; i++) begin
      push_pair({4'(i), 20'hC0FFE}, {20'h0BEEF, 4'(i)});
      frame_pair(32);
    end
    check("uf_stream", 64'(uf_cycles), 64'(exp_uf));

    // Reset mid left word discards buffered data
    push_pair(24'hFFFFFF, 24'hFFFFFF);
    push_pair(24'h123123, 24'h456456);
    half_frame(1'b0, 32, 1'b0, 10);
    half_frame(1'b1, 32, 1'b1, 0);
    push_pair(24'h5A5A5A, 24'hA5A5A5);
    frame_pair(32);
    check("uf_reset", 64'(uf_cycles), 64'(exp_uf));

    // Short half-frames truncate the word
    push_pair(24'hFFFFFF, 24'hFFFFFF);
    frame_pair(16);
    frame_pair(16);
    frame_pair(32);
    check("uf_short", 64'(uf_cycles), 64'(exp_uf));

    // Close the last checked frame
    half_frame(1'b0, 2, 1'b0, 0);
    check("sb_left", 64'(sb_q.size()), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
